// File: rtl/isp_pkg.sv
// Shared ISP definitions: window-controller FSM states, default frame geometry
// and the median sort pipeline depth.
package isp_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GAP  = 2'd1,
        S_LINE = 2'd2
    } win_state_e;

    localparam int DEF_IMG_W       = 960;
    localparam int DEF_IMG_H       = 540;
    localparam int MEDIAN_PIPE_LAT = 3;
    localparam int ROW_W           = 11;

    // Row counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [ROW_W-1:0] row_sat_inc(input logic [ROW_W-1:0] row);
        return (row == {ROW_W{1'b1}}) ? row : row + ROW_W'(1);
    endfunction

endpackage

// File: rtl/median_win_ctrl_sync_delay.sv
// sync_delay: fixed-latency, reset-cleared shift register used to realign
// sideband signals with the median pipeline output.
module sync_delay #(
    parameter int W   = 4,
    parameter int LAT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage_r [LAT];

    // Shift chain; reset flushes every stage so nothing stale leaks out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                stage_r[i] <= {W{1'b0}};
            end
        end else begin
            stage_r[0] <= d;
            for (int i = 1; i < LAT; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign q = stage_r[LAT-1];

endmodule

// File: rtl/median_win_ctrl.sv
// 3x3 median window sequencer: pixel position tracking, line-buffer/window
// control and sync realignment. Border flagging needs MEDIAN_EDGE_BYPASS_EN.
module median_win_ctrl
    import isp_pkg::*;
#(
    parameter int IMG_W    = DEF_IMG_W,
    parameter int IMG_H    = DEF_IMG_H,
    parameter int PIPE_LAT = MEDIAN_PIPE_LAT,
    parameter int AW       = $clog2(IMG_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pre_vsync,
    input  logic             pre_hsync,
    input  logic             pre_de,
    output logic             lb_wr_en,
    output logic [AW-1:0]    lb_addr,
    output logic             win_shift,
    output logic             edge_flag,
    output logic             post_vsync,
    output logic             post_hsync,
    output logic             post_de,
    output logic [ROW_W-1:0] row_cnt,
    output logic             frame_err
);

    localparam int CW  = $clog2(IMG_W + 1);
    localparam int LAT = PIPE_LAT + 1;
    localparam logic [CW-1:0]    COL_MAX   = CW'(IMG_W);
    localparam logic [AW-1:0]    ADDR_LAST = AW'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX   = ROW_W'(IMG_H);

    win_state_e       state_r, state_s;
    logic             vsync_d_r, de_d_r;
    logic [CW-1:0]    col_r, col_s, col_eff_s;
    logic [ROW_W-1:0] row_r, row_s;
    logic             frame_err_r, err_s;
    logic             lb_wr_en_r, wr_s;
    logic [AW-1:0]    lb_addr_r, addr_s;
    logic             win_shift_r;
    logic             pix_s, border_s;
    logic             vsync_rise_s, de_rise_s, de_fall_s;

    assign vsync_rise_s = pre_vsync & ~vsync_d_r;
    assign de_rise_s    = pre_de & ~de_d_r;
    assign de_fall_s    = ~pre_de & de_d_r;

    // State, counters and registered control outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            vsync_d_r   <= 1'b0;
            de_d_r      <= 1'b0;
            col_r       <= {CW{1'b0}};
            row_r       <= {ROW_W{1'b0}};
            frame_err_r <= 1'b0;
            lb_wr_en_r  <= 1'b0;
            lb_addr_r   <= {AW{1'b0}};
            win_shift_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            vsync_d_r   <= pre_vsync;
            de_d_r      <= pre_de;
            col_r       <= col_s;
            row_r       <= row_s;
            frame_err_r <= err_s;
            lb_wr_en_r  <= wr_s;
            lb_addr_r   <= addr_s;
            win_shift_r <= pix_s;
        end
    end

    // Next state and per-pixel control; the first pixel of a line is taken on
    // the de rise itself so the write lands one cycle after it is sampled.
    always_comb begin
        state_s   = state_r;
        col_s     = col_r;
        row_s     = row_r;
        err_s     = frame_err_r;
        col_eff_s = col_r;
        pix_s     = 1'b0;
        wr_s      = 1'b0;
        addr_s    = lb_addr_r;
        if (vsync_rise_s) begin
            state_s = S_GAP;
            row_s   = {ROW_W{1'b0}};
            col_s   = {CW{1'b0}};
            err_s   = 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    state_s = S_IDLE;
                end
                S_GAP: begin
                    if (de_rise_s) begin
                        state_s   = S_LINE;
                        col_eff_s = {CW{1'b0}};
                        pix_s     = 1'b1;
                        if (row_r == ROW_MAX) begin
                            err_s = 1'b1;
                        end else begin
                            err_s = frame_err_r;
                        end
                    end else begin
                        state_s = S_GAP;
                    end
                end
                S_LINE: begin
                    if (de_fall_s) begin
                        state_s = S_GAP;
                        row_s   = row_sat_inc(row_r);
                    end else if (pre_de) begin
                        pix_s = 1'b1;
                    end else begin
                        pix_s = 1'b0;
                    end
                end
                default: begin
                    state_s = S_IDLE;
                end
            endcase
        end
        if (pix_s) begin
            if (col_eff_s < COL_MAX) begin
                wr_s   = 1'b1;
                addr_s = col_eff_s[AW-1:0];
                col_s  = col_eff_s + CW'(1);
            end else begin
                wr_s   = 1'b0;
                addr_s = ADDR_LAST;
                col_s  = COL_MAX;
                err_s  = 1'b1;
            end
        end else begin
            wr_s = 1'b0;
        end
    end

`ifdef MEDIAN_EDGE_BYPASS_EN
    localparam logic [CW-1:0]    COL_LAST = CW'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    // Border test on the incoming pixel; the 3x3 window shares its last row/column.
    always_comb begin
        if (pix_s) begin
            border_s = (row_r < ROW_W'(2)) || (col_eff_s < CW'(2)) ||
                       (row_r == ROW_LAST) || (col_eff_s == COL_LAST);
        end else begin
            border_s = 1'b0;
        end
    end
`else
    assign border_s = 1'b0;
`endif

    sync_delay #(
        .W   (4),
        .LAT (LAT)
    ) u_sync_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({border_s, pre_de, pre_hsync, pre_vsync}),
        .q     ({edge_flag, post_de, post_hsync, post_vsync})
    );

    assign lb_wr_en  = lb_wr_en_r;
    assign lb_addr   = lb_addr_r;
    assign win_shift = win_shift_r;
    assign row_cnt   = row_r;
    assign frame_err = frame_err_r;

endmodule

// File: tb/tb_median_win_ctrl.sv
// Scoreboard bench for median_win_ctrl at IMG_W=8, IMG_H=4; edge expectations
// follow MEDIAN_EDGE_BYPASS_EN.
module tb_median_win_ctrl;

    localparam int W   = 8;
    localparam int H   = 4;
    localparam int AW  = 3;
    localparam int LAT = 4;
    localparam int M_IDLE = 0;
    localparam int M_GAP  = 1;
    localparam int M_LINE = 2;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic          shift;
        logic [10:0]   row;
        logic          err;
    } lb_exp_t;

    typedef struct packed {
        logic edge_f;
        logic de;
        logic hs;
        logic vs;
    } post_exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pre_vsync, pre_hsync, pre_de;
    logic          lb_wr_en, win_shift, edge_flag;
    logic [AW-1:0] lb_addr;
    logic          post_vsync, post_hsync, post_de;
    logic [10:0]   row_cnt;
    logic          frame_err;

    int checks_cnt = 0;
    int errors_cnt = 0;

    lb_exp_t   lb_q[$];
    post_exp_t post_q[$];

    // Reference model state
    int   m_state, m_row, m_col, m_last_addr;
    logic m_err, m_pvs, m_pde;

    median_win_ctrl #(.IMG_W(W), .IMG_H(H), .PIPE_LAT(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pre_vsync  (pre_vsync),
        .pre_hsync  (pre_hsync),
        .pre_de     (pre_de),
        .lb_wr_en   (lb_wr_en),
        .lb_addr    (lb_addr),
        .win_shift  (win_shift),
        .edge_flag  (edge_flag),
        .post_vsync (post_vsync),
        .post_hsync (post_hsync),
        .post_de    (post_de),
        .row_cnt    (row_cnt),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE; m_row = 0; m_col = 0; m_last_addr = 0;
        m_err = 1'b0; m_pvs = 1'b0; m_pde = 1'b0;
        lb_q.delete();
        post_q.delete();
        for (int i = 0; i < LAT - 1; i++) post_q.push_back('0);
    endtask

    // Apply one cycle of inputs, predict the outputs, then compare after the edge.
    task automatic step(input logic r, input logic vs, input logic hs, input logic de);
        lb_exp_t   le;
        post_exp_t pe;
        logic vr, dr, df, pix, border;
        int ceff;
        pre_vsync = vs; pre_hsync = hs; pre_de = de; rst_n = r;
        if (r) begin
            vr = vs && !m_pvs; dr = de && !m_pde; df = !de && m_pde;
            pix = 1'b0; ceff = m_col;
            if (vr) begin
                m_state = M_GAP; m_row = 0; m_col = 0; m_err = 1'b0;
            end else if (m_state == M_GAP && dr) begin
                m_state = M_LINE; ceff = 0; pix = 1'b1;
                if (m_row == H) m_err = 1'b1;
            end else if (m_state == M_LINE && df) begin
                m_state = M_GAP;
                m_row = (m_row < 2047) ? m_row + 1 : 2047;
            end else if (m_state == M_LINE && de) begin
                pix = 1'b1;
            end
            border = 1'b0;
`ifdef MEDIAN_EDGE_BYPASS_EN
            border = pix && (m_row < 2 || ceff < 2 || m_row == H - 1 || ceff == W - 1);
`endif
            le.wr = pix && (ceff < W);
            if (pix && ceff < W) begin
                m_last_addr = ceff; m_col = ceff + 1;
            end else if (pix) begin
                m_last_addr = W - 1; m_err = 1'b1;
            end
            le.addr = AW'(m_last_addr); le.shift = pix; le.row = 11'(m_row); le.err = m_err;
            lb_q.push_back(le);
            pe.edge_f = border; pe.de = de; pe.hs = hs; pe.vs = vs;
            post_q.push_back(pe);
            m_pvs = vs; m_pde = de;
        end
        @(posedge clk);
        #1;
        if (!r) begin
            model_reset();
            le = '0; pe = '0;
        end else begin
            le = lb_q.pop_front();
            pe = post_q.pop_front();
        end
        check_eq("lb_wr_en",   32'(lb_wr_en),   32'(le.wr));
        check_eq("lb_addr",    32'(lb_addr),    32'(le.addr));
        check_eq("win_shift",  32'(win_shift),  32'(le.shift));
        check_eq("row_cnt",    32'(row_cnt),    32'(le.row));
        check_eq("frame_err",  32'(frame_err),  32'(le.err));
        check_eq("post_de",    32'(post_de),    32'(pe.de));
        check_eq("post_hsync", 32'(post_hsync), 32'(pe.hs));
        check_eq("post_vsync", 32'(post_vsync), 32'(pe.vs));
        check_eq("edge_flag",  32'(edge_flag),  32'(pe.edge_f));
    endtask

    task automatic frame_start();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic line(input int n_pix);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n_pix; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        pre_vsync = 1'b0; pre_hsync = 1'b0; pre_de = 1'b0; rst_n = 1'b0;
        model_reset();
        // Reset held, then de without a preceding vsync must not write
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        // Nominal frame
        frame_start();
        for (int l = 0; l < H; l++) line(W);
        // Long line sets frame_err until the next vsync rise
        frame_start();
        line(W + 2);
        line(W);
        // Too many lines in a frame
        frame_start();
        for (int l = 0; l < H + 2; l++) line(W);
        // vsync rise mid-line at col=3 while de stays high
        frame_start();
        step(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        line(W);
        // One-cycle reset pulse while post_de is high
        frame_start();
        step(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        frame_start();
        line(W);
        line(W);
        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
